// File: rtl/mem_lsu_ctrl.sv
// mem_lsu_ctrl: one-at-a-time load/store sequencer between the memory stage and the data bus.
// Latency: 4 cycles best case (IDLE, REQ, WAIT, DONE); 2 cycles for a misaligned access.
// Backpressure: ms_stall holds the pipeline until DONE; the bus throttles via dbus_gnt/dbus_rvalid.
//
// Optional feature: define LSU_TIMEOUT_EN to add a REQ/WAIT watchdog of TIMEOUT_CYCLES cycles
// (exception cause 11). Without it the controller waits on the bus indefinitely.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   ms_valid/ms_lsu_op/ms_size/ms_unsigned/ms_alu_res/ms_store_data/ms_rd
//                                  memory-stage operation, held stable while ms_stall=1
//   ms_stall                       pipeline hold
//   dbus_req/we/addr/be/wdata      bus request, held stable until dbus_gnt
//   dbus_gnt/rvalid/rdata/err      bus grant and response
//   wb_valid/wb_rd/wb_data         one-cycle load write-back
//   lsu_exc/lsu_exc_cause          one-cycle exception (01 misaligned, 10 bus error, 11 timeout)
module mem_lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_valid,
  input  logic [1:0]  ms_lsu_op,
  input  logic [1:0]  ms_size,
  input  logic        ms_unsigned,
  input  logic [31:0] ms_alu_res,
  input  logic [31:0] ms_store_data,
  input  logic [4:0]  ms_rd,
  output logic        ms_stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_err,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lsu_exc,
  output logic [1:0]  lsu_exc_cause
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic [4:0]  rd_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        exc_q;
  logic [1:0]  cause_q;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             expire;
  // cnt_q counts completed REQ/WAIT cycles; the current one is the last allowed.
  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Decode of the presented operation; reserved op 11 is not a memory op.
  logic        mem_op;
  logic        op_store;
  logic        misaligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  assign mem_op     = ms_valid & (ms_lsu_op == 2'b01 || ms_lsu_op == 2'b10);
  assign op_store   = (ms_lsu_op == 2'b10);
  // Size 11 is treated as word, hence the ms_size[1] test.
  assign misaligned = ((ms_size == 2'b01) & ms_alu_res[0]) |
                      (ms_size[1] & (ms_alu_res[1:0] != 2'b00));

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = ms_store_data;
    case (ms_size)
      2'b00: begin
        be_d    = 4'b0001 << ms_alu_res[1:0];
        wdata_d = {4{ms_store_data[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << ms_alu_res[1:0];
        wdata_d = {2{ms_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  logic [31:0] rshift;
  logic [31:0] load_ext;

  assign rshift = dbus_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = dbus_rdata;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'd0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   load_ext = uns_q ? {16'd0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      exc_q      <= 1'b0;
      cause_q    <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // Stray grant/response here is ignored.
          if (mem_op) begin
            addr_q  <= ms_alu_res;
            size_q  <= ms_size;
            uns_q   <= ms_unsigned;
            we_q    <= op_store;
            rd_q    <= ms_rd;
            be_q    <= be_d;
            wdata_q <= wdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
            if (misaligned) begin
              state_q <= S_DONE;
              exc_q   <= 1'b1;
              cause_q <= 2'b01;
            end else begin
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
`ifdef LSU_TIMEOUT_EN
          cnt_q <= cnt_q + CNT_W'(1);
          if (expire) begin
            state_q <= S_DONE;
            exc_q   <= 1'b1;
            cause_q <= 2'b11;
          end else if (dbus_gnt) begin
            state_q <= S_WAIT;
          end
`else
          if (dbus_gnt) state_q <= S_WAIT;
`endif
        end
        S_WAIT: begin
`ifdef LSU_TIMEOUT_EN
          cnt_q <= cnt_q + CNT_W'(1);
`endif
          // A response in the expiry cycle still completes normally.
          if (dbus_rvalid) begin
            state_q <= S_DONE;
            if (dbus_err) begin
              exc_q   <= 1'b1;
              cause_q <= 2'b10;
            end else if (!we_q && rd_q != 5'd0) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= rd_q;
              wb_data_q  <= load_ext;
            end
`ifdef LSU_TIMEOUT_EN
          end else if (expire) begin
            state_q <= S_DONE;
            exc_q   <= 1'b1;
            cause_q <= 2'b11;
`endif
          end
        end
        default: begin
          // DONE: strobes last exactly this one cycle.
          state_q    <= S_IDLE;
          wb_valid_q <= 1'b0;
          wb_rd_q    <= '0;
          wb_data_q  <= '0;
          exc_q      <= 1'b0;
          cause_q    <= '0;
        end
      endcase
    end
  end

  assign ms_stall      = ((state_q == S_IDLE) & mem_op) | (state_q == S_REQ) | (state_q == S_WAIT);
  assign dbus_req      = (state_q == S_REQ);
  assign dbus_we       = dbus_req & we_q;
  assign dbus_addr     = dbus_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dbus_be       = dbus_req ? be_q : 4'd0;
  assign dbus_wdata    = dbus_req ? wdata_q : 32'd0;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign lsu_exc       = exc_q;
  assign lsu_exc_cause = cause_q;

endmodule
